// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump engine.
package regdump_pkg;

  localparam int NREGS  = 32;
  localparam int ADDR_W = $clog2(NREGS);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    LOAD,
    SEND,
    CSUM
  } dump_state_t;

endpackage

// File: rtl/regdump_xor_acc.sv
// XOR accumulator that folds register words into the optional checksum.
module regdump_xor_acc
  import regdump_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] acc_value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_value <= '0;
    end else if (clear) begin
      acc_value <= '0;
    end else if (enable) begin
      acc_value <= acc_value ^ data_in;
    end
  end

endmodule

// File: rtl/regfile_dumper.sv
// Stalls the core and streams x0..x(NREGS-1) out over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dumper
  import regdump_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  dump_state_t state, state_next;
  logic handshake, word_final, load_word, finish, accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = DRAIN;
      DRAIN: state_next = LOAD;
      LOAD:  state_next = SEND;
      SEND: begin
        if (handshake && word_final) begin
`ifdef REGDUMP_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = IDLE;
`endif
        end
      end
      CSUM:  if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall, busy and valid are pure state decodes so reset clears them at once.
  always_comb begin
    busy       = (state != IDLE);
    cpu_stall  = (state != IDLE);
    out_valid  = (state == SEND) || (state == CSUM);
    handshake  = out_valid && out_ready;
    word_final = (out_idx == LAST_IDX);
    accept     = (state == IDLE) && start;
    load_word  = (state == LOAD) || ((state == SEND) && handshake && !word_final);
    finish     = handshake && out_last;
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_value;

  regdump_xor_acc #(
    .DATA_W (DATA_W)
  ) u_xor_acc (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .enable    (load_word),
    .data_in   (rd_data),
    .acc_value (acc_value)
  );
`endif

  // The next word is captured on the same edge as the current handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr  <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        rd_addr <= '0;
      end
      if (load_word) begin
        out_data <= rd_data;
        out_idx  <= rd_addr;
        rd_addr  <= rd_addr + ADDR_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
        out_last <= 1'b0;
`else
        out_last <= (rd_addr == LAST_IDX);
`endif
      end
`ifdef REGDUMP_CHECKSUM_EN
      if ((state == SEND) && handshake && word_final) begin
        out_data <= acc_value;
        out_idx  <= '0;
        out_last <= 1'b1;
      end
`endif
      if (finish) begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper with a behavioural register file and stream model.
module tb_regfile_dumper;
  import regdump_pkg::*;

  localparam int DATA_W = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int EXP_FAST   = 35;
  localparam int EXP_TOGGLE = 67;
`else
  localparam int EXP_FAST   = 34;
  localparam int EXP_TOGGLE = 65;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              cpu_stall, out_valid, out_last, busy, done;
  logic [ADDR_W-1:0] rd_addr, out_idx;
  logic [DATA_W-1:0] rd_data, out_data;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] dumped [$];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } word_t;

  typedef struct {
    int ready_mode;
    int preload;
    bit write_x5;
    int exp_done;
  } vec_t;

  word_t exp_q [$];
  int errors = 0;
  int checks = 0;

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  regfile_dumper #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cpu_stall (cpu_stall),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_regs(input int kind);
    for (int i = 0; i < NREGS; i++) begin
      case (kind)
        0:       regs[i] = DATA_W'(i * 3 + 1);
        1:       regs[i] = DATA_W'(i);
        default: regs[i] = $urandom();
      endcase
    end
  endtask

  // Start pulse sampled at E0; an optional core write to x5 lands on that same edge.
  task automatic apply_stimulus(input bit write_x5);
    start = 1'b1;
    @(posedge clk);
    if (write_x5) regs[5] = 32'hDEAD;
    #1;
    start = 1'b0;
  endtask

  task automatic build_model();
    logic [DATA_W-1:0] csum;
    csum = '0;
    exp_q.delete();
    for (int i = 0; i < NREGS; i++) begin
      word_t w;
      w.data = regs[i];
      w.idx  = ADDR_W'(i);
`ifdef REGDUMP_CHECKSUM_EN
      w.last = 1'b0;
`else
      w.last = (i == NREGS - 1);
`endif
      exp_q.push_back(w);
      csum = csum ^ regs[i];
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back('{data: csum, idx: '0, last: 1'b1});
`endif
  endtask

  // Called at the sample point just after E0; returns at the sample point where done is high.
  task automatic run_dump(input int ready_mode, input int repulse_idx, input int abort_idx,
                          input int exp_done, output logic [DATA_W-1:0] last_data);
    int words_left, model_done, done_at, bad_valid, bad_stall, bad_stable, bad_after;
    bit held, aborted, model_valid;
    word_t prev, w;
    build_model();
    dumped.delete();
    words_left = exp_q.size();
    model_done = -1;
    done_at = -1;
    bad_valid = 0;
    bad_stall = 0;
    bad_stable = 0;
    held = 1'b0;
    aborted = 1'b0;
    last_data = '0;
    prev = '0;
    for (int n = 0; n < 400; n++) begin
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
      model_valid = (n >= 2) && (words_left > 0);
      if (out_valid !== model_valid) bad_valid++;
      if (busy !== 1'b1 || cpu_stall !== 1'b1) bad_stall++;
      if (held && (out_data !== prev.data || out_idx !== prev.idx || out_last !== prev.last)) bad_stable++;
      if (abort_idx >= 0 && out_valid === 1'b1 && int'(out_idx) == abort_idx) begin
        reset = 1'b0;
        #1;
        check_output("async_reset_outputs",
                     64'({busy, cpu_stall, out_valid, out_last, done, rd_addr, out_idx, out_data}), 64'd0);
        aborted = 1'b1;
        break;
      end
      start = (repulse_idx >= 0) && (out_valid === 1'b1) && (int'(out_idx) == repulse_idx);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (model_valid && out_ready) begin
        words_left--;
        if (words_left == 0) model_done = n + 1;
      end
      held = out_valid && !out_ready;
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("extra_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check_output($sformatf("word_data_idx%0d", w.idx), 64'(out_data), 64'(w.data));
          check_output($sformatf("word_idx_n%0d", n), 64'(out_idx), 64'(w.idx));
          check_output($sformatf("word_last_idx%0d", w.idx), 64'(out_last), 64'(w.last));
        end
        dumped.push_back(out_data);
        last_data = out_data;
      end
      prev = '{data: out_data, idx: out_idx, last: out_last};
      step();
      start = 1'b0;
    end
    out_ready = 1'b0;
    start = 1'b0;
    check_output("valid_timing_bad_cycles", 64'(bad_valid), 64'd0);
    check_output("stall_busy_bad_cycles", 64'(bad_stall), 64'd0);
    check_output("held_word_unstable_cycles", 64'(bad_stable), 64'd0);
    if (aborted) begin
      step();
      reset = 1'b1;
      bad_after = 0;
      for (int k = 0; k < 5; k++) begin
        step();
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad_after++;
      end
      check_output("no_done_after_reset", 64'(bad_after), 64'd0);
    end else begin
      if (done_at < 0) check_output("done_timeout", 64'd0, 64'd1);
      check_output("done_cycle_vs_model", 64'(done_at), 64'(model_done));
      if (exp_done >= 0) check_output("done_cycle_fixed", 64'(done_at), 64'(exp_done));
      check_output("idle_in_done_cycle", 64'({busy, cpu_stall, out_valid}), 64'd0);
      check_output("words_missing", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    vec_t vecs [5];
    logic [DATA_W-1:0] last;
    int bad_idle;

    vecs[0] = '{ready_mode: 0, preload: 0, write_x5: 1'b0, exp_done: EXP_FAST};
    vecs[1] = '{ready_mode: 1, preload: 0, write_x5: 1'b0, exp_done: EXP_TOGGLE};
    vecs[2] = '{ready_mode: 0, preload: 0, write_x5: 1'b1, exp_done: EXP_FAST};
    vecs[3] = '{ready_mode: 2, preload: 2, write_x5: 1'b0, exp_done: -1};
    vecs[4] = '{ready_mode: 2, preload: 2, write_x5: 1'b1, exp_done: -1};

    preload_regs(0);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state",
                 64'({busy, cpu_stall, out_valid, out_last, done, rd_addr, out_idx, out_data}), 64'd0);
    reset = 1'b1;
    step();
    check_output("idle_after_reset", 64'({busy, cpu_stall, out_valid, done}), 64'd0);

    for (int v = 0; v < 5; v++) begin
      preload_regs(vecs[v].preload);
      apply_stimulus(vecs[v].write_x5);
      run_dump(vecs[v].ready_mode, -1, -1, vecs[v].exp_done, last);
      if (vecs[v].preload == 0) begin
        check_output("x0_value", 64'(dumped[0]), 64'd1);
        check_output("x31_value", 64'(dumped[31]), 64'd94);
      end
      if (vecs[v].write_x5) check_output("x5_written_in_start_cycle", 64'(dumped[5]), 64'hDEAD);
      repeat (2) step();
    end

    // A start seen mid-dump must not queue a second dump.
    preload_regs(0);
    apply_stimulus(1'b0);
    run_dump(0, 10, -1, EXP_FAST, last);
    bad_idle = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (busy !== 1'b0 || out_valid !== 1'b0) bad_idle++;
    end
    check_output("repulse_ignored", 64'(bad_idle), 64'd0);

    // Start raised during the done cycle is accepted on the next edge.
    apply_stimulus(1'b0);
    run_dump(0, -1, -1, EXP_FAST, last);
    apply_stimulus(1'b0);
    check_output("restart_in_done_cycle", 64'({busy, cpu_stall}), 64'd3);
    run_dump(0, -1, -1, EXP_FAST, last);
    step();

    // Reset while word 15 is on the stream, then a clean dump from index 0.
    apply_stimulus(1'b0);
    run_dump(0, -1, 15, -1, last);
    apply_stimulus(1'b0);
    run_dump(2, -1, -1, -1, last);
    check_output("post_reset_first_idx0", 64'(dumped[0]), 64'(regs[0]));
    step();

    preload_regs(1);
    apply_stimulus(1'b0);
    run_dump(0, -1, -1, EXP_FAST, last);
`ifdef REGDUMP_CHECKSUM_EN
    check_output("checksum_identity", 64'(last), 64'h0);
`else
    check_output("final_word_identity", 64'(last), 64'd31);
`endif
    step();
    regs[31] = 32'hFF;
    apply_stimulus(1'b0);
    run_dump(0, -1, -1, EXP_FAST, last);
`ifdef REGDUMP_CHECKSUM_EN
    check_output("checksum_x31_ff", 64'(last), 64'hE0);
`else
    check_output("final_word_x31_ff", 64'(last), 64'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
